mux_4_1: RTL and testbench

MUX_4_1 -- requirements
Module: mux_4_1

---
 rtl/mux_4_1_pkg.sv | 13 +
 rtl/mux_4_1_dec.sv | 26 ++
 rtl/mux_4_1.sv | 108 ++++++++++
 tb/tb_mux_4_1.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_4_1_pkg.sv
// Shared constants for the 8-input mux slice: select width, input count and
// the values the output registers take while reset is held.
package mux_4_1_pkg;

   localparam int SEL_W = 3;
   localparam int N_IN  = 8;

   localparam logic [SEL_W-1:0] SEL_RST   = 3'd0;
   localparam logic             Y_RST_BIT = 1'b0;
   localparam logic             VALID_RST = 1'b0;
   localparam logic             PAR_RST   = 1'b0;

endpackage

// File: rtl/mux_4_1_dec.sv
// Binary-to-one-hot select decoder; any sel with X/Z bits decodes to all-zeros
// so the downstream AND-OR produces zero.
module mux_4_1_dec
   import mux_4_1_pkg::*;
(
   input  logic [SEL_W-1:0] sel,
   output logic [N_IN-1:0]  onehot
);

   // decode sel to one-hot
   always_comb begin
      onehot = {N_IN{1'b0}};
      case (sel)
         3'd0:    onehot = 8'b0000_0001;
         3'd1:    onehot = 8'b0000_0010;
         3'd2:    onehot = 8'b0000_0100;
         3'd3:    onehot = 8'b0000_1000;
         3'd4:    onehot = 8'b0001_0000;
         3'd5:    onehot = 8'b0010_0000;
         3'd6:    onehot = 8'b0100_0000;
         3'd7:    onehot = 8'b1000_0000;
         default: onehot = 8'b0000_0000;
      endcase
   end

endmodule

// File: rtl/mux_4_1.sv
// 8-input WIDTH-bit mux with combinational and registered outputs.
// Optional registered parity output y_par when MUX_4_1_PARITY_EN is defined.
module mux_4_1
   import mux_4_1_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i0,
   input  logic [WIDTH-1:0] i1,
   input  logic [WIDTH-1:0] i2,
   input  logic [WIDTH-1:0] i3,
   input  logic [WIDTH-1:0] i4,
   input  logic [WIDTH-1:0] i5,
   input  logic [WIDTH-1:0] i6,
   input  logic [WIDTH-1:0] i7,
   input  logic [SEL_W-1:0] sel,
   output logic [WIDTH-1:0] y,
   output logic [N_IN-1:0]  sel_onehot,
   output logic [WIDTH-1:0] y_q,
   output logic [SEL_W-1:0] sel_q,
   output logic             y_valid
`ifdef MUX_4_1_PARITY_EN
   ,
   output logic             y_par
`endif
);

   logic [WIDTH-1:0] din_s [N_IN];
   logic [N_IN-1:0]  onehot_s;
   logic [WIDTH-1:0] y_d;
   logic [SEL_W-1:0] sel_d;
   logic             y_valid_d;
   logic             y_valid_q;

   assign din_s[0] = i0;
   assign din_s[1] = i1;
   assign din_s[2] = i2;
   assign din_s[3] = i3;
   assign din_s[4] = i4;
   assign din_s[5] = i5;
   assign din_s[6] = i6;
   assign din_s[7] = i7;

   mux_4_1_dec u_dec (
      .sel    (sel),
      .onehot (onehot_s)
   );

   // one-hot AND-OR selection; an all-zero one-hot yields zero
   always_comb begin
      y_d = {WIDTH{1'b0}};
      for (int n = 0; n < N_IN; n++) begin
         y_d = y_d | (din_s[n] & {WIDTH{onehot_s[n]}});
      end
   end

   assign y          = y_d;
   assign sel_onehot = onehot_s;

   // next-state for the output registers
   always_comb begin
      sel_d     = sel;
      y_valid_d = 1'b1;
   end

   // output registers, cleared asynchronously by rst
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y_q       <= {WIDTH{Y_RST_BIT}};
         sel_q     <= SEL_RST;
         y_valid_q <= VALID_RST;
      end else begin
         y_q       <= y_d;
         sel_q     <= sel_d;
         y_valid_q <= y_valid_d;
      end
   end

   assign y_valid = y_valid_q;

`ifdef MUX_4_1_PARITY_EN
   function automatic logic parity_of(input logic [WIDTH-1:0] v);
      return ^v;
   endfunction

   logic y_par_d;
   logic y_par_q;

   // parity of the selected data
   always_comb begin
      y_par_d = parity_of(y_d);
   end

   // registered parity alongside y_q
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y_par_q <= PAR_RST;
      end else begin
         y_par_q <= y_par_d;
      end
   end

   assign y_par = y_par_q;
`endif

endmodule

// File: tb/tb_mux_4_1.sv
// Scoreboard bench for mux_4_1: stimulus pushes expectations, a negedge
// monitor pops and compares combinational and registered outputs.
module tb_mux_4_1;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] i0, i1, i2, i3, i4, i5, i6, i7;
   logic [2:0]   sel;
   logic [W-1:0] y;
   logic [7:0]   sel_onehot;
   logic [W-1:0] y_q;
   logic [2:0]   sel_q;
   logic         y_valid;
`ifdef MUX_4_1_PARITY_EN
   logic         y_par;
`endif

   mux_4_1 #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .i0         (i0),
      .i1         (i1),
      .i2         (i2),
      .i3         (i3),
      .i4         (i4),
      .i5         (i5),
      .i6         (i6),
      .i7         (i7),
      .sel        (sel),
      .y          (y),
      .sel_onehot (sel_onehot),
      .y_q        (y_q),
      .sel_q      (sel_q),
      .y_valid    (y_valid)
`ifdef MUX_4_1_PARITY_EN
      ,
      .y_par      (y_par)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;
   int cyc    = 0;

   typedef struct {
      logic [W-1:0] y;
      logic [7:0]   oh;
   } comb_t;

   typedef struct {
      int           due;
      logic [W-1:0] yq;
      logic [2:0]   selq;
      logic         par;
   } reg_t;

   comb_t        comb_q [$];
   reg_t         reg_q  [$];
   comb_t        ce;
   reg_t         re;
   logic [W-1:0] din [8];
   logic [W-1:0] last_y;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
   endtask

   // Reference model: the spec's rules expressed directly.
   function automatic logic [W-1:0] ref_y(input logic [2:0] s);
      if ($isunknown(s)) return '0;
      return din[s];
   endfunction

   function automatic logic [7:0] ref_oh(input logic [2:0] s);
      if ($isunknown(s)) return 8'd0;
      return 8'd1 << s;
   endfunction

   function automatic logic ref_par(input logic [W-1:0] v);
      return ($countones(v) % 2) == 1;
   endfunction

   task automatic apply(input logic [2:0] s);
      @(posedge clk);
      #1;
      sel = s;
      i0 = din[0]; i1 = din[1]; i2 = din[2]; i3 = din[3];
      i4 = din[4]; i5 = din[5]; i6 = din[6]; i7 = din[7];
      last_y = ref_y(s);
      comb_q.push_back('{ref_y(s), ref_oh(s)});
      reg_q.push_back('{cyc + 1, ref_y(s), s, ref_par(ref_y(s))});
   endtask

   task automatic clear_din();
      for (int k = 0; k < 8; k++) din[k] = '0;
   endtask

   // Monitor: combinational outputs first, then any registered result due now.
   always @(negedge clk) begin
      if (comb_q.size() > 0) begin
         ce = comb_q.pop_front();
         chk("y", 32'(y), 32'(ce.y));
         chk("sel_onehot", 32'(sel_onehot), 32'(ce.oh));
      end
      if (reg_q.size() > 0 && reg_q[0].due <= cyc) begin
         re = reg_q.pop_front();
         chk("y_valid", 32'(y_valid), 32'(1'b1));
         chk("y_q", 32'(y_q), 32'(re.yq));
         chk("sel_q", 32'(sel_q), 32'(re.selq));
`ifdef MUX_4_1_PARITY_EN
         chk("y_par", 32'(y_par), 32'(re.par));
`endif
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      sel = 3'd0;
      clear_din();
      i0 = '0; i1 = '0; i2 = '0; i3 = '0; i4 = '0; i5 = '0; i6 = '0; i7 = '0;
      last_y = '0;
      #2;
      chk("rst_y_q", 32'(y_q), 32'd0);
      chk("rst_sel_q", 32'(sel_q), 32'd0);
      chk("rst_y_valid", 32'(y_valid), 32'd0);
      #10;
      chk("rst_hold_y_valid", 32'(y_valid), 32'd0);
      rst = 1'b0;
      #1;
      chk("valid_before_edge", 32'(y_valid), 32'd0);
      reg_q.push_back('{cyc + 1, ref_y(sel), sel, ref_par(ref_y(sel))});

      // i0 selected
      clear_din(); din[0] = 4'd1;
      apply(3'd0);

      // walk sel 1..7 with only the matching input set, 100 time units per step
      for (int s = 1; s < 8; s++) begin
         clear_din(); din[s] = 4'd1;
         apply(3'(s));
         repeat (9) @(posedge clk);
      end

      // non-selected inputs ignored
      for (int k = 0; k < 8; k++) din[k] = 4'hF;
      din[3] = 4'h0;
      apply(3'd3);
      din[5] = 4'h7; din[0] = 4'h2;
      apply(3'd3);

      // parity case: odd number of ones
      clear_din(); din[2] = 4'b1011;
      apply(3'd2);

      // non-binary select
      for (int k = 0; k < 8; k++) din[k] = 4'(k + 3);
      apply(3'bx1x);

      // mid-stream reset between clock edges
      for (int k = 0; k < 8; k++) din[k] = 4'($urandom);
      apply(3'd6);
      repeat (2) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_y_q", 32'(y_q), 32'd0);
      chk("mid_rst_sel_q", 32'(sel_q), 32'd0);
      chk("mid_rst_y_valid", 32'(y_valid), 32'd0);
      chk("mid_rst_y", 32'(y), 32'(last_y));
      chk("mid_rst_onehot", 32'(sel_onehot), 32'(ref_oh(sel)));
      @(posedge clk);
      @(posedge clk);
      #3;
      chk("mid_rst_hold_valid", 32'(y_valid), 32'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_valid_wait", 32'(y_valid), 32'd0);
      reg_q.push_back('{cyc + 1, ref_y(sel), sel, ref_par(ref_y(sel))});

      // randomized traffic, sel and data changing together
      for (int n = 0; n < 40; n++) begin
         for (int k = 0; k < 8; k++) din[k] = 4'($urandom);
         apply(3'($urandom_range(0, 7)));
         if ($urandom_range(0, 3) == 0) @(posedge clk);
      end

      repeat (3) @(negedge clk);
      #1;
      chk("drain", 32'(comb_q.size() + reg_q.size()), 32'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
